// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage feeding the zero-detector X input.
// A WIDTH-bit word is taken through a valid/ready handshake and shifted out
// one bit per clock. Back-to-back words run with no idle gap, frame_done marks
// the last bit of each word and word_cnt counts completed words (mod 256).
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic [7:0]       word_cnt
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit that leaves the word first in the chosen bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drops the bit just sent so the next one sits in the first_bit position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             x_out_q, x_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       word_cnt_q, word_cnt_d;

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sreg_adv;

    assign last_bit   = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_LAST);
    assign load_ready = (state_q == ST_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;
    assign sreg_adv   = advance(sreg_q);

    // Next-state logic: load on accept, otherwise shift or fall back to idle.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        x_out_d      = x_out_q;
        bit_valid_d  = bit_valid_q;
        word_cnt_d   = word_cnt_q;
        // Registered so it is high exactly while the last bit is on x_out.
        frame_done_d = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_PEN);

        if (last_bit) begin
            word_cnt_d = word_cnt_q + 8'd1;
        end

        if (accept) begin
            state_d     = ST_SHIFT;
            sreg_d      = din;
            bit_cnt_d   = '0;
            x_out_d     = first_bit(din);
            bit_valid_d = 1'b1;
        end else if (last_bit) begin
            state_d     = ST_IDLE;
            x_out_d     = IDLE_LEVEL;
            bit_valid_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            sreg_d      = sreg_adv;
            bit_cnt_d   = bit_cnt_q + 1'b1;
            x_out_d     = first_bit(sreg_adv);
        end
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            x_out_q      <= IDLE_LEVEL;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            word_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            x_out_q      <= x_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign x_out      = x_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first and an LSB-first instance.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_a = 8'h00, din_b = 8'h00;
    logic       lv_a = 1'b0, lv_b = 1'b0;
    logic       rdy_a, x_a, bv_a, fd_a;
    logic       rdy_b, x_b, bv_b, fd_b;
    logic [7:0] wc_a, wc_b;

    int checks = 0;
    int failures = 0;

    // expected entries: {last_bit_flag, bit}
    logic [1:0] q_a[$];
    logic [1:0] q_b[$];
    logic [7:0] ewc_a, ewc_b;
    logic [1:0] e_a, e_b;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .load_valid(lv_a), .load_ready(rdy_a),
        .x_out(x_a), .bit_valid(bv_a), .frame_done(fd_a), .word_cnt(wc_a)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .load_valid(lv_b), .load_ready(rdy_b),
        .x_out(x_b), .bit_valid(bv_b), .frame_done(fd_b), .word_cnt(wc_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word, wait for ready, queue its expected bits, pass the accept edge.
    task automatic send(input bit sel, input logic [7:0] w);
        int n = 0;
        if (sel == 1'b0) begin
            din_a = w;
            lv_a = 1'b1;
            while (!rdy_a && n < 50) begin step(); n++; end
            for (int i = 0; i < 8; i++) q_a.push_back({(i == 7), w[7 - i]});
        end else begin
            din_b = w;
            lv_b = 1'b1;
            while (!rdy_b && n < 50) begin step(); n++; end
            for (int i = 0; i < 8; i++) q_b.push_back({(i == 7), w[i]});
        end
        chk("send_ready_wait", (n < 50), 1);
        step();
        lv_a = 1'b0;
        lv_b = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bv_a || bv_b) && n < 50) begin step(); n++; end
        chk("idle_wait", (n < 50), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor A: pops one expected bit per valid cycle; idle line checked otherwise.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            ewc_a = 8'd0;
        end else begin
            chk("word_cnt_a", wc_a, ewc_a);
            if (bv_a) begin
                if (q_a.size() == 0) begin
                    chk("extra_bit_a", q_a.size(), 1);
                end else begin
                    e_a = q_a.pop_front();
                    chk("x_out_a", x_a, e_a[0]);
                    chk("frame_done_a", fd_a, e_a[1]);
                    if (e_a[1]) ewc_a = ewc_a + 8'd1;
                end
            end else begin
                chk("idle_x_a", x_a, 1);
                chk("idle_fd_a", fd_a, 0);
            end
        end
    end

    // Monitor B: same checks for the LSB-first instance.
    always @(negedge clk) begin
        if (rst) begin
            q_b.delete();
            ewc_b = 8'd0;
        end else begin
            chk("word_cnt_b", wc_b, ewc_b);
            if (bv_b) begin
                if (q_b.size() == 0) begin
                    chk("extra_bit_b", q_b.size(), 1);
                end else begin
                    e_b = q_b.pop_front();
                    chk("x_out_b", x_b, e_b[0]);
                    chk("frame_done_b", fd_b, e_b[1]);
                    if (e_b[1]) ewc_b = ewc_b + 8'd1;
                end
            end else begin
                chk("idle_x_b", x_b, 1);
                chk("idle_fd_b", fd_b, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hb;
        int run;
        int max_run;

        // Reset state
        step();
        step();
        chk("rst_x_a", x_a, 1);
        chk("rst_bv_a", bv_a, 0);
        chk("rst_fd_a", fd_a, 0);
        chk("rst_wc_a", wc_a, 0);
        chk("rst_ready_a", rdy_a, 1);
        chk("rst_x_b", x_b, 1);
        rst = 1'b0;
        step();

        // Single word A5, MSB first: 1,0,1,0,0,1,0,1
        send(1'b0, 8'hA5);
        hb = 8'b10100101;
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit", x_a, hb[7 - i]);
            chk("a5_valid", bv_a, 1);
            chk("a5_fd", fd_a, (i == 7));
            step();
        end
        chk("a5_idle_x", x_a, 1);
        chk("a5_idle_bv", bv_a, 0);
        chk("a5_wc", wc_a, 1);

        // LSB first, 01: 1 then seven 0s, then idle 1
        send(1'b1, 8'h01);
        run = 0;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_bit", x_b, (i == 0));
            if (x_b == 1'b0) run++; else run = 0;
            if (run > max_run) max_run = run;
            step();
        end
        chk("lsb_zero_run", max_run, 7);
        chk("lsb_idle_x", x_b, 1);
        chk("lsb_wc", wc_b, 1);

        // Back-to-back FF then 00 with load_valid held high
        din_a = 8'hFF;
        lv_a = 1'b1;
        chk("b2b_ready_idle", rdy_a, 1);
        for (int i = 0; i < 8; i++) q_a.push_back({(i == 7), 1'b1});
        step();
        din_a = 8'h00;
        for (int c = 1; c <= 16; c++) begin
            chk("b2b_valid", bv_a, 1);
            chk("b2b_bit", x_a, (c <= 8));
            chk("b2b_fd", fd_a, (c == 8 || c == 16));
            chk("b2b_ready", rdy_a, (c == 8 || c == 16));
            if (c == 8) for (int i = 0; i < 8; i++) q_a.push_back({(i == 7), 1'b0});
            step();
            if (c == 8) lv_a = 1'b0;
        end
        chk("b2b_end_bv", bv_a, 0);
        chk("b2b_wc", wc_a, 3);

        // Busy ignore: 3C offered during bit 3 of A5
        send(1'b0, 8'hA5);
        repeat (3) step();
        din_a = 8'h3C;
        lv_a = 1'b1;
        chk("busy_ready", rdy_a, 0);
        step();
        lv_a = 1'b0;
        wait_idle();
        step();
        chk("busy_wc", wc_a, 4);

        // Reset mid-word during bit 4 of A5
        send(1'b0, 8'hA5);
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("mid_rst_x", x_a, 1);
        chk("mid_rst_bv", bv_a, 0);
        chk("mid_rst_fd", fd_a, 0);
        chk("mid_rst_wc", wc_a, 0);
        step();
        rst = 1'b0;
        send(1'b0, 8'h0F);
        hb = 8'b00001111;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_bit", x_a, hb[7 - i]);
            step();
        end
        chk("post_rst_wc", wc_a, 1);

        // Reset wins over a simultaneous accept
        din_a = 8'hFF;
        lv_a = 1'b1;
        rst = 1'b1;
        step();
        lv_a = 1'b0;
        chk("rst_prio_bv", bv_a, 0);
        chk("rst_prio_wc", wc_a, 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_prio_idle", bv_a, 0);

        // Counter wrap: 256 words back-to-back
        for (int i = 0; i < 256; i++) begin
            send(1'b0, 8'(i * 37 + 5));
            if (i == 255) chk("wrap_255", wc_a, 255);
        end
        wait_idle();
        step();
        chk("wrap_0", wc_a, 0);
        chk("sb_empty_a", q_a.size(), 0);
        chk("sb_empty_b", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
